wb_slv_regs: RTL and testbench

WB_SLV_REGS -- requirements
Module: wb_slv_regs

---
 rtl/wb_slv_pkg.sv | 26 ++
 rtl/wb_slv_regfile.sv | 49 ++++
 rtl/wb_slv_regs.sv | 206 ++++++++++++++++++++
 tb/tb_wb_slv_regs.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_slv_pkg.sv
// Shared definitions for the Wishbone register slave: FSM state encoding,
// the identification word and the fixed register indices.
package wb_slv_pkg;

    // Bus-side transaction states (WAIT is a keyword, hence the prefix).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    // Identification word returned from word index 0.
    localparam logic [31:0] ID_VALUE = 32'h05B5_0001;

    // Fixed register map.
    localparam int IDX_ID  = 0;   // read-only ID word
    localparam int IDX_CNT = 1;   // read-only completed-transaction counter
    localparam int IDX_RW0 = 2;   // first read/write register

    // Bus geometry.
    localparam int ADR_W  = 12;
    localparam int WIDX_W = 10;   // word index = byte address [11:2]
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

endpackage

// File: rtl/wb_slv_regfile.sv
// Byte-enabled read/write register storage for the Wishbone register slave.
// One write port with a 4-bit lane enable, one combinational read port.
// Storage is split into one byte-wide array per lane so each lane has a
// single driver; out-of-range reads return zero.
module wb_slv_regfile
    import wb_slv_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk50,
    input  logic              arst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [SEL_W-1:0]  wr_lane,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Per-lane storage: cleared by reset, written only when this lane is enabled.
            always_ff @(posedge clk50 or negedge arst_n) begin
                if (!arst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_mem[i] <= 8'd0;
                    end
                end else if (wr_en && wr_lane[gi] && wr_in_range) begin
                    lane_mem[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = rd_in_range ? lane_mem[rd_addr] : 8'd0;
        end
    endgenerate

endmodule

// File: rtl/wb_slv_regs.sv
// Wishbone classic register slave with programmable wait states.
// Word 0 is a read-only ID, word 1 a read-only count of completed
// transactions, words 2..NREGS-1 are byte-enabled read/write registers.
// Optional build macro WB_SLV_ERR_EN: adds wb_err_o and answers unmapped
// accesses with an error cycle instead of an acknowledge.
module wb_slv_regs
    import wb_slv_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk50,
    input  logic              arst_n,
    input  logic [ADR_W-1:0]  wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic              wb_we_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o
`ifdef WB_SLV_ERR_EN
    ,
    output logic              wb_err_o
`endif
);

    localparam int RF_DEPTH = NREGS - IDX_RW0;
    localparam int RF_AW    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

    localparam logic [WIDX_W:0]   NREGS_W   = (WIDX_W+1)'(NREGS);
    localparam logic [WIDX_W-1:0] IDX_ID_W  = WIDX_W'(IDX_ID);
    localparam logic [WIDX_W-1:0] IDX_CNT_W = WIDX_W'(IDX_CNT);
    localparam logic [WIDX_W-1:0] IDX_RW0_W = WIDX_W'(IDX_RW0);
    localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    wb_state_e state_reg;
    wb_state_e state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;

    // Request fields captured on the accepting edge.
    logic [WIDX_W-1:0] idx_reg;
    logic              we_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [DATA_W-1:0] dat_reg;

    logic [DATA_W-1:0] trans_cnt_reg;

    logic request;
    logic capture;
    logic enter_ack;
    logic in_ack;

    // Byte-address bits [1:0] carry no meaning for word-wide registers.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    assign request = wb_cyc_i & wb_stb_i;
    assign in_ack  = (state_reg == ST_ACK);

    // Next-state logic: accept in IDLE, count down wait states, abort on lost cycle.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        capture       = 1'b0;
        enter_ack     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_ACK;
                        enter_ack  = 1'b1;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    // Master gave up: drop the transaction, leave the counter alone.
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_ACK;
                    enter_ack  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and wait-state counter registers.
    always_ff @(posedge clk50 or negedge arst_n) begin
        if (!arst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Capture the request on the accepting edge; later bus changes are ignored.
    always_ff @(posedge clk50 or negedge arst_n) begin
        if (!arst_n) begin
            idx_reg <= '0;
            we_reg  <= 1'b0;
            sel_reg <= '0;
            dat_reg <= '0;
        end else if (capture) begin
            idx_reg <= wb_adr_i[ADR_W-1:2];
            we_reg  <= wb_we_i;
            sel_reg <= wb_sel_i;
            dat_reg <= wb_dat_i;
        end
    end

    // Write path. With zero wait states the ACK is entered on the very edge
    // that accepts the request, so the live bus fields are used from IDLE;
    // otherwise the captured fields are used.
    logic              src_bus;
    logic [WIDX_W-1:0] wr_idx;
    logic              wr_we;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_dat;
    logic              wr_mapped;
    logic              rf_wr_en;
    logic [RF_AW-1:0]  rf_wr_addr;

    assign src_bus    = (state_reg == ST_IDLE);
    assign wr_idx     = src_bus ? wb_adr_i[ADR_W-1:2] : idx_reg;
    assign wr_we      = src_bus ? wb_we_i  : we_reg;
    assign wr_sel     = src_bus ? wb_sel_i : sel_reg;
    assign wr_dat     = src_bus ? wb_dat_i : dat_reg;
    assign wr_mapped  = ({1'b0, wr_idx} < NREGS_W);
    assign rf_wr_en   = enter_ack & wr_we & wr_mapped & (wr_idx >= IDX_RW0_W);
    assign rf_wr_addr = RF_AW'(wr_idx - IDX_RW0_W);

    // Read path, always addressed by the captured index.
    logic              rd_mapped;
    logic [RF_AW-1:0]  rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic [DATA_W-1:0] read_word;

    assign rd_mapped  = ({1'b0, idx_reg} < NREGS_W);
    assign rf_rd_addr = RF_AW'(idx_reg - IDX_RW0_W);

    wb_slv_regfile #(
        .DEPTH (RF_DEPTH),
        .AW    (RF_AW)
    ) u_regfile (
        .clk50   (clk50),
        .arst_n  (arst_n),
        .wr_en   (rf_wr_en),
        .wr_addr (rf_wr_addr),
        .wr_lane (wr_sel),
        .wr_data (wr_dat),
        .rd_addr (rf_rd_addr),
        .rd_data (rf_rd_data)
    );

    // Register map decode for the addressed word; unmapped words read as zero.
    always_comb begin
        read_word = '0;
        if (rd_mapped) begin
            if (idx_reg == IDX_ID_W) begin
                read_word = ID_VALUE;
            end else if (idx_reg == IDX_CNT_W) begin
                read_word = trans_cnt_reg;
            end else begin
                read_word = rf_rd_data;
            end
        end
    end

    // Count completed mapped transactions as the ack cycle retires, so a read
    // of the counter reports the total before the current transaction.
    always_ff @(posedge clk50 or negedge arst_n) begin
        if (!arst_n) begin
            trans_cnt_reg <= '0;
        end else if (in_ack && rd_mapped) begin
            trans_cnt_reg <= trans_cnt_reg + 32'd1;
        end
    end

    // Outputs derive only from registered state, so they drop to zero the
    // moment reset asserts.
    assign wb_dat_o = in_ack ? read_word : '0;

`ifdef WB_SLV_ERR_EN
    assign wb_ack_o = in_ack & rd_mapped;
    assign wb_err_o = in_ack & ~rd_mapped;
`else
    assign wb_ack_o = in_ack;
`endif

endmodule

// File: tb/tb_wb_slv_regs.sv
// Scoreboard bench for wb_slv_regs: a driver issues transactions and pushes
// the expected response (data, ack/err kind, cycle) from an array-based model;
// a monitor pops and compares whenever the slave responds.
module tb_wb_slv_regs;

    localparam int NREGS       = 16;
    localparam int WAIT_CYCLES = 3;
    localparam logic [31:0] ID_WORD = 32'h05B5_0001;
`ifdef WB_SLV_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          err;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [NREGS];
    logic [31:0] model_cnt;
    int          total = 0;
    int          bad   = 0;
    int          cyc_cnt = 0;

    logic        clk50 = 1'b0;
    logic        arst_n;
    logic [11:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        resp_err;

    // Second slave with zero wait states for back-to-back timing.
    logic [11:0] b_adr;
    logic [31:0] b_dat_i;
    logic [31:0] b_dat_o;
    logic        b_we;
    logic [3:0]  b_sel;
    logic        b_stb;
    logic        b_cyc;
    logic        b_ack;
    logic        b_err;

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc_cnt <= cyc_cnt + 1;

    wb_slv_regs #(.NREGS(NREGS), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
        .clk50    (clk50),
        .arst_n   (arst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_ack_o (ack)
`ifdef WB_SLV_ERR_EN
        ,
        .wb_err_o (resp_err)
`endif
    );

    wb_slv_regs #(.NREGS(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk50    (clk50),
        .arst_n   (arst_n),
        .wb_adr_i (b_adr),
        .wb_dat_i (b_dat_i),
        .wb_dat_o (b_dat_o),
        .wb_we_i  (b_we),
        .wb_sel_i (b_sel),
        .wb_stb_i (b_stb),
        .wb_cyc_i (b_cyc),
        .wb_ack_o (b_ack)
`ifdef WB_SLV_ERR_EN
        ,
        .wb_err_o (b_err)
`endif
    );

`ifndef WB_SLV_ERR_EN
    assign resp_err = 1'b0;
    assign b_err    = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model_mem[i] = 32'd0;
        model_cnt = 32'd0;
    endtask

    // One bus transaction. abort_at>0 drops the cycle that many clocks after
    // issue (before the ack would come); perturb scrambles the bus after the
    // accepting edge, which the slave must ignore.
    task automatic do_xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input int abort_at, input bit perturb);
        int   idx;
        int   waited;
        exp_t e;
        idx = int'(a[11:2]);
        @(negedge clk50);
        adr = a; dat_i = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
        if (abort_at == 0) begin
            if (idx >= NREGS) begin
                e.data = 32'd0;
                e.err  = ERR_BUILD;
            end else begin
                if (w && idx >= 2) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
                e.data = (idx == 0) ? ID_WORD : (idx == 1) ? model_cnt : model_mem[idx];
                e.err  = 1'b0;
                model_cnt = model_cnt + 32'd1;
            end
            e.at = cyc_cnt + 1 + WAIT_CYCLES;
            exp_q.push_back(e);
            $display("xfer adr=%h we=%b sel=%b wdata=%h expect=%h err=%b", a, w, s, d, e.data, e.err);
        end else begin
            $display("xfer adr=%h we=%b sel=%b wdata=%h aborted after %0d", a, w, s, d, abort_at);
        end
        @(negedge clk50);
        if (perturb) begin
            stb = 1'b0; adr = 12'($urandom); dat_i = $urandom; we = ~we; sel = ~sel;
        end
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk50);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            repeat (WAIT_CYCLES + 2) @(negedge clk50);
            return;
        end
        waited = 1;
        while (!(ack || resp_err) && waited < 40) begin
            @(negedge clk50);
            waited++;
        end
        if (!(ack || resp_err)) begin
            total++; bad++;
            $display("FAIL ack_timeout: no response for adr=%h after %0d cycles", a, waited);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk50);
    endtask

    // Monitor: every response must match the head of the scoreboard queue;
    // outside responses the read bus must be zero.
    always @(negedge clk50) begin
        exp_t e;
        if (arst_n) begin
            if (ack || resp_err) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_response: got ack=%b err=%b required none", ack, resp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", dat_o, e.data);
                    check("resp_kind", {30'd0, ack, resp_err}, {30'd0, ~e.err, e.err});
                    check("resp_cycle", cyc_cnt, e.at);
                end
            end else begin
                check("idle_data", dat_o, 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        adr = '0; dat_i = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0;
        b_adr = '0; b_dat_i = '0; b_we = 1'b0; b_sel = '0; b_stb = 1'b0; b_cyc = 1'b0;
        model_reset();
        repeat (3) @(negedge clk50);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_dat", dat_o, 32'd0);
        arst_n = 1'b1;
        @(negedge clk50);

        // Byte-lane write then readback, then the counter (2 completed before it).
        do_xfer(12'h008, 1'b1, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0);
        do_xfer(12'h008, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        do_xfer(12'h004, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        // ID read with wait-state timing.
        do_xfer(12'h000, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        // Aborted write after one wait cycle: nothing written, nothing counted.
        do_xfer(12'h00C, 1'b1, 32'h1234_5678, 4'hF, 2, 1'b0);
        do_xfer(12'h00C, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        do_xfer(12'h004, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        // Writes to read-only words, then an unmapped read.
        do_xfer(12'h000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        do_xfer(12'h004, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b1);
        do_xfer(12'h000, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        do_xfer(12'h100, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        do_xfer(12'h004, 1'b0, 32'd0, 4'hF, 0, 1'b0);

        // Reset during the wait states of a write.
        do_xfer(12'h010, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
        @(negedge clk50);
        adr = 12'h010; dat_i = 32'hA5A5_5A5A; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk50);
        arst_n = 1'b0;
        #1;
        check("midreset_ack", {31'd0, ack}, 32'd0);
        check("midreset_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk50);
        arst_n = 1'b1;
        model_reset();
        $display("reset asserted during write wait states");
        do_xfer(12'h010, 1'b0, 32'd0, 4'hF, 0, 1'b0);
        do_xfer(12'h004, 1'b0, 32'd0, 4'hF, 0, 1'b0);

        // Randomized traffic including unmapped words, aborts and bus noise.
        for (int t = 0; t < 150; t++) begin
            logic [9:0]  idx;
            logic [11:0] a;
            int          ab;
            if ($urandom_range(0, 9) == 0) idx = 10'($urandom_range(NREGS, 1023));
            else                           idx = 10'($urandom_range(0, NREGS - 1));
            a  = {idx, 2'($urandom_range(0, 3))};
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, WAIT_CYCLES)) : 0;
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    ab, 1'($urandom_range(0, 1)));
        end

        // Zero-wait slave: request held high gives ack, idle, ack, idle, ...
        @(negedge clk50);
        b_adr = 12'h000; b_we = 1'b0; b_sel = 4'hF; b_cyc = 1'b1; b_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk50);
            check("b2b_ack", {31'd0, b_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b_dat", b_dat_o, (i % 2 == 0) ? ID_WORD : 32'd0);
            $display("b2b cycle %0d ack=%b dat=%h", i, b_ack, b_dat_o);
            if (i == 5) begin
                b_cyc = 1'b0; b_stb = 1'b0;
            end
        end
        @(negedge clk50);
        b_adr = 12'h004; b_cyc = 1'b1; b_stb = 1'b1;
        @(negedge clk50);
        check("b0_cnt_ack", {31'd0, b_ack}, 32'd1);
        check("b0_cnt_dat", b_dat_o, 32'd3);
        check("b0_err", {31'd0, b_err}, 32'd0);
        b_cyc = 1'b0; b_stb = 1'b0;
        @(negedge clk50);
        check("b0_ack_drop", {31'd0, b_ack}, 32'd0);

        repeat (5) @(negedge clk50);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
